// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic MAC feeders: operand/array defaults,
// feeder state encoding and the lane-slice helper.
package tpu_pkg;

  localparam int BITS_AB_DEF = 8;
  localparam int DIM_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } feeder_state_e;

  // LSB position of element idx inside a packed vector of width-bit elements.
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/systolic_a_feeder_if.sv
// Tile-loader / MAC-grid side bundle of the A-operand feeder.
interface systolic_a_feeder_if
  import tpu_pkg::*;
#(
  parameter int BITS_AB  = BITS_AB_DEF,
  parameter int DIM      = DIM_DEF,
  parameter int ROW_BITS = $clog2(DIM)
);
  logic                   wr_en;
  logic [ROW_BITS-1:0]    wr_row;
  logic [DIM*BITS_AB-1:0] wr_data;
  logic                   start;
  logic                   busy;
  logic                   a_valid;
  logic                   en_out;
  logic [DIM*BITS_AB-1:0] a_out;
  logic                   done;

  modport master (
    output wr_en, wr_row, wr_data, start,
    input  busy, a_valid, en_out, a_out, done
  );

  modport slave (
    input  wr_en, wr_row, wr_data, start,
    output busy, a_valid, en_out, a_out, done
  );
endinterface

// File: rtl/systolic_skew_lane.sv
// One skewed output lane: presents row element (t - LANE) while streaming,
// zero before the lane's window opens and after it closes.
module systolic_skew_lane
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF,
  parameter int T_BITS  = 4,
  parameter int LANE    = 0
) (
  input  logic [T_BITS-1:0]      t_i,
  input  logic                   active_i,
  input  logic [DIM*BITS_AB-1:0] row_i,
  output logic [BITS_AB-1:0]     lane_o
);

  // Signed offset into the row; negative before the window opens.
  logic signed [T_BITS+1:0] k;
  logic                     in_window;

  assign k         = $signed({2'b00, t_i}) - $signed((T_BITS+2)'(LANE));
  assign in_window = !k[T_BITS+1] && (k < $signed((T_BITS+2)'(DIM)));

  always_comb begin
    lane_o = '0;
    if (active_i && in_window) begin
      lane_o = row_i[lane_lsb(32'(k[T_BITS-1:0]), BITS_AB) +: BITS_AB];
    end
  end

endmodule

// File: rtl/systolic_a_feeder.sv
// A-operand feeder: buffers one DIM x DIM tile and streams it diagonally
// skewed into the MAC grid rows, driving the grid enable while streaming.
module systolic_a_feeder
  import tpu_pkg::*;
#(
  parameter int BITS_AB  = BITS_AB_DEF,
  parameter int DIM      = DIM_DEF,
  parameter int ROW_BITS = $clog2(DIM)
) (
  input logic               clk,
  input logic               rst,
  systolic_a_feeder_if.slave bus
);

  localparam int                T_BITS = $clog2(2*DIM-1);
  localparam logic [T_BITS-1:0] T_LAST = T_BITS'(2*DIM-2);

  feeder_state_e                   state_q, state_d;
  logic [T_BITS-1:0]               t_q, t_d;
  logic [DIM-1:0][DIM*BITS_AB-1:0] mem_q;
  logic [DIM-1:0][BITS_AB-1:0]     lanes;
  logic                            streaming;
  logic                            wr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  assign wr_ok = (state_q == IDLE) && bus.wr_en
              && ({1'b0, bus.wr_row} < (ROW_BITS+1)'(DIM));

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (wr_ok) begin
      mem_q[bus.wr_row] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        t_d = '0;
        if (bus.start) state_d = STREAM;
      end
      STREAM: begin
        if (t_q == T_LAST) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  always_comb begin
    streaming   = (state_q == STREAM);
    bus.busy    = (state_q != IDLE);
    bus.a_valid = streaming;
    bus.en_out  = streaming;
    bus.done    = (state_q == DONE);
  end

  for (genvar r = 0; r < DIM; r++) begin : g_lane
    systolic_skew_lane #(
      .BITS_AB(BITS_AB),
      .DIM    (DIM),
      .T_BITS (T_BITS),
      .LANE   (r)
    ) u_lane (
      .t_i     (t_q),
      .active_i(streaming),
      .row_i   (mem_q[r]),
      .lane_o  (lanes[r])
    );
  end

  assign bus.a_out = lanes;

endmodule
